pdm_mic_decimator: RTL
======================

Name: pdm_mic_decimator

Overview:
- Parametrised PDM microphone front end.
- Generates the mic clock and samples one or two PDM data streams (stereo: two mics share one data line, split by clock phase).
- Boxcar-decimates each stream to signed PCM with saturation and clip flagging.
- Emits a single-cycle sample strobe feeding the FIR, recorder and volume path. Also exports the PDM tick used by the output modulator.

Parameters:
- CLK_DIV, 32, system clocks per mic clock period; even, >=4.
- DECIM, 256, PDM ticks per output sample; power of 2, 4..4096.
- OUT_W, 8, PCM output width, 4..16.
- STEREO, 0, 0 = channel 0 only; 1 = channels 0 and 1.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- en_in  in  1  run enable
- mic_data_in  in  1  raw PDM data from pad
- mic_clk_out  out  1  mic clock, 50% duty
- pdm_tick_out  out  1  single-cycle strobe, once per mic clock period
- sample_valid_out  out  1  single-cycle strobe, new PCM sample
- ch0_out  out  OUT_W  signed PCM, channel 0
- ch1_out  out  OUT_W  signed PCM, channel 1; 0 when STEREO=0
- clip_out  out  2  per-channel saturation flag for the current sample

Behaviour:
- Reset: all outputs 0. Divider counter, tick counter and tallies are 0. Synchronizer flops are 0.
- Divider:
  - cnt runs 0..CLK_DIV-1 and wraps.
  - mic_clk_out is registered: 1 while cnt < CLK_DIV/2.
  - pdm_tick_out = 1 in the cycle cnt == CLK_DIV-1.
- Data sampling:
  - mic_data_in passes through a 2-flop synchronizer; all sampling uses the synchronized bit.
  - Channel 0 samples at cnt == CLK_DIV/2-1 (last high cycle).
  - Channel 1 samples at cnt == CLK_DIV-1 (last low cycle).
- Tally:
  - L = log2(DECIM). Tally width is L+1.
  - tick_cnt counts pdm ticks 0..DECIM-1.
  - Each channel's sampled bit is added to its tally.
- Sample close:
  - Occurs on the tick where tick_cnt == DECIM-1, after that tick's channel-1 sample.
  - Per channel: centered = tally - DECIM/2, range [-DECIM/2, +DECIM/2].
  - Saturate centered to L-bit signed [-DECIM/2, DECIM/2-1]. clip bit = 1 only if saturation occurred (tally == DECIM).
  - Align to OUT_W:
    - L > OUT_W: arithmetic shift right by L-OUT_W (truncate).
    - L < OUT_W: shift left by OUT_W-L.
    - L == OUT_W: unchanged.
  - ch*_out and clip_out register the aligned results.
  - sample_valid_out pulses in the same cycle those registers update: 1 cycle after the closing pdm_tick_out.
  - Outputs hold until the next close.
  - Tallies restart with the closing tick's bits excluded, so each window is exactly DECIM ticks with no sample lost or double-counted.
- Output rate: one sample_valid_out every CLK_DIV*DECIM clocks (8192 at defaults).
- en_in low:
  - Divider, tick_cnt and tallies held at 0.
  - mic_clk_out = 0, no strobes.
  - ch*_out and clip_out keep their last values.
- en_in rising: the counter starts at 0. The first sample_valid_out comes CLK_DIV*DECIM+1 cycles later.
- en_in falling mid-window: the partial window is discarded.
- rst_in takes priority over en_in. rst_in mid-window discards the partial window and clears outputs.
- STEREO=0: channel 1 logic is absent; ch1_out = 0 and clip_out[1] = 0.

Decomposition:
- Package pdm_pkg holds:
  - localparam function computing L = $clog2(DECIM).
  - the saturate/align function, parametrised by L and OUT_W.
  - channel index constants CH0 = 0, CH1 = 1.
- Sub-module pdm_clkgen: divider, mic_clk_out, pdm_tick_out, and the two channel sample strobes.
- The decimator instantiates pdm_clkgen plus one tally/close slice per channel, built with a generate loop over STEREO+1.

Test Plan:
- Defaults, mic_data_in constant 1 -> every sample ch0_out = 127, clip_out[0] = 1. sample_valid_out spacing is exactly 8192 cycles. mic_clk_out period is 32 (16 high).
- Defaults, constant 0 -> ch0_out = -128, clip_out = 0. Alternating 1/0 per tick -> ch0_out = 0.
- STEREO=1: data driven 1 at channel-0 sampling points and 0 at channel-1 points -> ch0_out = 127, ch1_out = -128, clip_out = 2'b01.
- DECIM=64, OUT_W=8: 48 ones per window -> ch0_out = 64. All zeros -> -128 (left-shift path). DECIM=1024, OUT_W=8: 768 ones -> 64 (right-shift path).
- rst_in asserted 1 cycle after tick 100 of a window -> all outputs 0. The first sample_valid_out arrives 8193 cycles after rst_in deasserts, and its value reflects only post-reset data.
- en_in dropped at tick 200 then restored -> no strobe while low, ch0_out holds its old value, and the next sample covers exactly 256 fresh ticks.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared constants and the close-time saturate/align arithmetic used by the
// PDM microphone decimator.
package pdm_pkg;

    localparam int CH0         = 0;
    localparam int CH1         = 1;
    localparam int MAX_L       = 12;
    localparam int MAX_W       = 16;
    localparam int TALLY_EXT_W = MAX_L + 1;

    typedef struct packed {
        logic             clip;
        logic [MAX_W-1:0] pcm;
    } close_t;

    function automatic int log2_decim(input int decim);
        return $clog2(decim);
    endfunction

    // Tally of ones -> centered, saturated to l-bit signed, aligned to out_w bits.
    function automatic close_t sat_align(input logic [TALLY_EXT_W-1:0] tally,
                                         input int l, input int out_w);
        close_t res;
        int     half;
        int     centered;
        half     = 1 << (l - 1);
        centered = int'({19'd0, tally}) - half;
        res.clip = 1'b0;
        if (centered > half - 1) begin
            centered = half - 1;
            res.clip = 1'b1;
        end
        if (l > out_w) begin
            centered = centered >>> (l - out_w);
        end else if (l < out_w) begin
            centered = centered << (out_w - l);
        end
        res.pcm = centered[MAX_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/pdm_clkgen.sv
// Mic clock divider: 50% duty mic clock, one tick per period and the two
// per-channel data sample strobes (last high cycle, last low cycle).
module pdm_clkgen
    import pdm_pkg::*;
#(
    parameter int CLK_DIV = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       mic_clk,
    output logic       tick,
    output logic [1:0] smp
);

    localparam int CW   = $clog2(CLK_DIV);
    localparam int HALF = CLK_DIV / 2;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          run;

    // The first enabled cycle holds cnt at 0 so every run begins with a full period.
    always_comb begin
        cnt_next = '0;
        if (en && run) begin
            cnt_next = (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            run     <= 1'b0;
            mic_clk <= 1'b0;
            tick    <= 1'b0;
            smp     <= '0;
        end else begin
            cnt      <= cnt_next;
            run      <= en;
            mic_clk  <= en && (cnt_next < CW'(HALF));
            tick     <= en && (cnt_next == CW'(CLK_DIV - 1));
            smp[CH0] <= en && (cnt_next == CW'(HALF - 1));
            smp[CH1] <= en && (cnt_next == CW'(CLK_DIV - 1));
        end
    end

endmodule

// File: rtl/pdm_mic_decimator.sv
// PDM microphone front end: mic clock, 2-flop data sync, per-channel boxcar
// decimation to saturated signed PCM with a one-cycle sample strobe.
module pdm_mic_decimator
    import pdm_pkg::*;
#(
    parameter int CLK_DIV = 32,
    parameter int DECIM   = 256,
    parameter int OUT_W   = 8,
    parameter int STEREO  = 0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             mic_data_in,
    output logic             mic_clk_out,
    output logic             pdm_tick_out,
    output logic             sample_valid_out,
    output logic [OUT_W-1:0] ch0_out,
    output logic [OUT_W-1:0] ch1_out,
    output logic [1:0]       clip_out
);

    localparam int L   = log2_decim(DECIM);
    localparam int NCH = STEREO + 1;

    logic [1:0]       sync;
    logic             data_bit;
    logic             tick;
    logic [1:0]       smp;
    logic [L-1:0]     tick_cnt;
    logic             close;
    logic [OUT_W-1:0] pcm_v  [2];
    logic             clip_v [2];
    logic             unused_smp;

    assign data_bit     = sync[1];
    assign pdm_tick_out = tick & en_in;
    assign close        = en_in && tick && (tick_cnt == L'(DECIM - 1));
    assign unused_smp   = ^smp;

    pdm_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk     (clk_in),
        .rst     (rst_in),
        .en      (en_in),
        .mic_clk (mic_clk_out),
        .tick    (tick),
        .smp     (smp)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync             <= '0;
            tick_cnt         <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            sync             <= {sync[0], mic_data_in};
            sample_valid_out <= close;
            if (!en_in) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + L'(1);
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [L:0]       tally;
        logic [L:0]       total;
        logic [OUT_W-1:0] pcm_r;
        logic             clip_r;
        close_t           res;
        logic             unused_res;

        // total folds in the bit sampled this cycle, so the closing tick's
        // channel-1 sample lands in the window it closes.
        always_comb begin
            total = tally + {{L{1'b0}}, smp[i] & data_bit};
            res   = sat_align(TALLY_EXT_W'(total), L, OUT_W);
        end

        assign unused_res = ^res;

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                tally  <= '0;
                pcm_r  <= '0;
                clip_r <= 1'b0;
            end else if (!en_in) begin
                tally <= '0;
            end else if (close) begin
                tally  <= '0;
                pcm_r  <= res.pcm[OUT_W-1:0];
                clip_r <= res.clip;
            end else begin
                tally <= total;
            end
        end

        assign pcm_v[i]  = pcm_r;
        assign clip_v[i] = clip_r;
    end

    if (STEREO == 0) begin : g_mono
        assign pcm_v[CH1]  = '0;
        assign clip_v[CH1] = 1'b0;
    end

    assign ch0_out  = pcm_v[CH0];
    assign ch1_out  = pcm_v[CH1];
    assign clip_out = {clip_v[CH1], clip_v[CH0]};

endmodule
